l_mac_accumulator: RTL
======================

Name: l_mac_accumulator

Overview:
- Sequential multiply-accumulate engine that sits directly downstream of the L_mult basic op.
- Consumes a stream of 16-bit operand pairs and forms the G.729 L_mac chain: acc = L_add(acc, L_mult(x, y)), with the same saturation rules as the C reference.
- Serves correlation, energy and autocorrelation loops: LPC analysis, pitch search and codebook search.
- Returns one 32-bit saturated result per job, plus a sticky overflow flag.

Parameters:
- LEN_W, 7, width of the job length input. Supports up to 127 pairs; 40-sample subframe and 80-sample frame jobs are typical.

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle job start pulse; honoured only in IDLE
- len  input  LEN_W  number of operand pairs in the job; sampled on start
- acc_init  input  32  initial accumulator value; sampled on start
- in_valid  input  1  operand pair valid
- in_ready  output  1  engine accepts pair this cycle
- x  input  16  signed Q15 operand
- y  input  16  signed Q15 operand
- busy  output  1  job in progress
- done  output  1  one-cycle pulse; result is final
- result  output  32  saturated accumulator; holds until next start
- overflow  output  1  sticky saturation flag for the current job

Behaviour:
- All outputs reset to 0; FSM resets to IDLE. Reset mid-job abandons the job: no done, counters and pipeline cleared.
- FSM states are IDLE, ACCUM, DRAIN, DONE.
- IDLE -> ACCUM on start:
  - acc <= acc_init; cnt <= len; overflow <= 0; busy <= 1.
  - start with len = 0 goes to DONE instead; done pulses the next cycle with result = acc_init.
- ACCUM:
  - in_ready = (cnt != 0).
  - A pair is accepted when in_valid & in_ready; cnt decrements on each accept.
  - After the last accept (cnt hits 0), go to DRAIN.
- Pipeline per accepted pair:
  - Stage 1 registers the L_mult product, (x*y)<<1. The single saturating case 0x8000*0x8000 gives 0x7FFFFFFF with mult_ovf = 1.
  - Stage 2 applies acc <= sat32(acc + product), where sat32 clamps to 0x7FFFFFFF or 0x80000000.
  - overflow |= mult_ovf | add_ovf.
- Latency and throughput:
  - A pair accepted in cycle T is reflected in acc at the end of cycle T+2.
  - Back-to-back accepts give one pair per cycle.
  - Bubbles on in_valid insert no stale data; stage-1 valid bit gates stage 2.
- DRAIN waits until the stage-1 and stage-2 valids are both clear, then goes to DONE.
- DONE:
  - done = 1 for exactly one cycle; busy drops in the same cycle.
  - Return to IDLE. result = acc and remains stable.
- Saturated acc keeps accumulating from the clamped value, so later opposite-sign terms can pull it back. This matches the C L_mac chain; overflow stays 1.
- start while busy is ignored. in_valid outside ACCUM is ignored and in_ready = 0.
- Arithmetic is signed two's complement throughout. The adder uses a 33-bit intermediate for overflow detection: overflow when the operand signs match and the sum sign differs.

Optional Feature:
- Macro: L_MAC_ROUND_EN.
- Defined:
  - Adds output result_hi[15:0] = extract_h(L_add(result, 0x00008000)), with saturation.
  - Valid with done; held with result.
  - Rounding saturation also sets overflow.
- Undefined: the port and its logic are absent; everything else is unchanged.

Decomposition:
- Shared package g729_basic_pkg holds:
  - MAX_32 = 0x7FFFFFFF, MIN_32 = 0x80000000, MAX_16 = 0x7FFF, MIN_16 = 0x8000;
  - the FSM state enum;
  - a sat32 add function.
- One natural sub-module: the existing L_mult basic op, instantiated combinationally in front of the stage-1 register.
- The adder saturation stays inline, via the package function.

Test Plan:
- Energy sum:
  - Stimulus: len = 3, acc_init = 0, pairs (0x4000, 0x4000) x3 back-to-back.
  - Required: result = 0x60000000, overflow = 0, done exactly 3 cycles after the last accept.
- Multiply saturation:
  - Stimulus: len = 1, pair (0x8000, 0x8000).
  - Required: result = 0x7FFFFFFF, overflow = 1.
- Accumulate saturation with recovery:
  - Stimulus: acc_init = 0x7FFF0000, pairs (0x7FFF, 0x7FFF) then (0x8000, 0x4000).
  - Required: acc clamps to 0x7FFFFFFF, then result = 0x3FFFFFFF, overflow = 1.
- len = 0:
  - Stimulus: acc_init = 0x00000001.
  - Required: done the cycle after start, result = 0x00000001, no pair consumed.
- Bubbles and ignored start:
  - Stimulus: len = 4 with in_valid toggling 1,0,1,0,..., and start re-pulsed mid-job.
  - Required: same result as the gap-free run; second start ignored.
- Reset mid-job:
  - Stimulus: assert reset after 2 of 5 pairs.
  - Required: busy, done, result and overflow all 0 next cycle. A new job then runs correctly.
- With L_MAC_ROUND_EN:
  - Stimulus: result 0x12348000.
  - Required: result_hi = 0x1235.

Source files
------------

// File: rtl/g729_basic_pkg.sv
// Shared G.729 basic-op definitions: Q15/Q31 limits, MAC FSM states, saturating 32-bit add.
package g729_basic_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 32;

  localparam logic [ACC_W-1:0]  MAX_32 = 32'h7FFF_FFFF;
  localparam logic [ACC_W-1:0]  MIN_32 = 32'h8000_0000;
  localparam logic [DATA_W-1:0] MAX_16 = 16'h7FFF;
  localparam logic [DATA_W-1:0] MIN_16 = ~MAX_16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_e;

  typedef struct packed {
    logic             ovf;
    logic [ACC_W-1:0] sum;
  } sat32_res_t;

  // L_add: 33-bit sign-extended sum; top two bits disagree exactly when the
  // operand signs match and the 32-bit sum sign differs.
  function automatic sat32_res_t sat32_add(input logic [ACC_W-1:0] a,
                                           input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    sat32_res_t     r;
    s     = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    r.ovf = s[ACC_W] ^ s[ACC_W-1];
    r.sum = r.ovf ? (s[ACC_W] ? MIN_32 : MAX_32) : s[ACC_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/l_mac_accumulator_l_mult.sv
// L_mult basic op: saturating Q15 x Q15 -> Q31 product, purely combinational.
module l_mac_accumulator_l_mult
  import g729_basic_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [ACC_W-1:0]  product_c,
  output logic              ovf_c
);

  logic signed [ACC_W-1:0] raw_c;

  // Signed product doubled; -1.0 * -1.0 is the only case that cannot be represented.
  always_comb begin
    raw_c     = ACC_W'($signed(x)) * ACC_W'($signed(y));
    product_c = raw_c << 1;
    ovf_c     = 1'b0;
    if ((x == MIN_16) && (y == MIN_16)) begin
      product_c = MAX_32;
      ovf_c     = 1'b1;
    end
  end

endmodule

// File: rtl/l_mac_accumulator.sv
// L_mac chain engine: acc = L_add(acc, L_mult(x, y)) over a job of len pairs.
// Optional rounded-high-half output enabled by defining L_MAC_ROUND_EN.
module l_mac_accumulator
  import g729_basic_pkg::*;
#(
  parameter int unsigned LEN_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ACC_W-1:0]  acc_init,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              overflow
`ifdef L_MAC_ROUND_EN
  ,
  output logic [DATA_W-1:0] result_hi
`endif
);

  mac_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] prod_q, prod_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_ovf_q, s1_ovf_d;
  logic             s2_valid_q, s2_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] result_q, result_d;

  logic [ACC_W-1:0] l_mult_c;
  logic             mult_ovf_c;
  logic             accept_c;
  sat32_res_t       add_c;

`ifdef L_MAC_ROUND_EN
  logic [DATA_W-1:0] result_hi_q, result_hi_d;
  logic [ACC_W-1:0]  fin_c;
  sat32_res_t        round_c;
`endif

  l_mac_accumulator_l_mult u_l_mult (
    .x         (x),
    .y         (y),
    .product_c (l_mult_c),
    .ovf_c     (mult_ovf_c)
  );

  // Stage 1: capture the product of each accepted pair; valid bit gates stage 2.
  always_comb begin
    accept_c   = (state_q == ST_ACCUM) && in_ready_q && in_valid;
    prod_d     = prod_q;
    s1_ovf_d   = s1_ovf_q;
    s1_valid_d = accept_c;
    s2_valid_d = s1_valid_q;
    if (accept_c) begin
      prod_d   = l_mult_c;
      s1_ovf_d = mult_ovf_c;
    end
    add_c = sat32_add(acc_q, prod_q);
  end

`ifdef L_MAC_ROUND_EN
  // Rounding source is acc_init for an empty job, otherwise the drained accumulator.
  always_comb begin
    fin_c   = (state_q == ST_IDLE) ? acc_init : acc_q;
    round_c = sat32_add(fin_c, 32'h0000_8000);
  end
`endif

  // Next-state, stage-2 accumulate and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
`ifdef L_MAC_ROUND_EN
    result_hi_d = result_hi_q;
`endif

    if (s1_valid_q) begin
      acc_d = add_c.sum;
      ovf_d = ovf_q | s1_ovf_q | add_c.ovf;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = acc_init;
          ovf_d = 1'b0;
          if (len == '0) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            result_d = acc_init;
`ifdef L_MAC_ROUND_EN
            result_hi_d = round_c.sum[ACC_W-1:DATA_W];
            ovf_d       = round_c.ovf;
`endif
          end else begin
            state_d = ST_ACCUM;
            cnt_d   = len;
            busy_d  = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (accept_c) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          result_d = acc_q;
`ifdef L_MAC_ROUND_EN
          result_hi_d = round_c.sum[ACC_W-1:DATA_W];
          ovf_d       = ovf_d | round_c.ovf;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_ACCUM) && (cnt_d != '0);
  end

  // State, pipeline and output registers; reset abandons any job in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_ovf_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
`ifdef L_MAC_ROUND_EN
      result_hi_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      s1_valid_q <= s1_valid_d;
      s1_ovf_q   <= s1_ovf_d;
      s2_valid_q <= s2_valid_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
`ifdef L_MAC_ROUND_EN
      result_hi_q <= result_hi_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;
`ifdef L_MAC_ROUND_EN
  assign result_hi = result_hi_q;
`endif

endmodule
